// File: rtl/mul_pkg.sv
// Shared widths, FSM state encoding and partial-product placement for the
// sequential 16x16 multiplier.
package mul_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned HALF_W = 8;
  localparam int unsigned PROD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Align a 16-bit partial product to its weight for the given P state.
  function automatic logic [PROD_W-1:0] place_partial(input logic [2*HALF_W-1:0] pp,
                                                      input state_e st);
    logic [PROD_W-1:0] res;
    case (st)
      ST_P0:        res = {16'h0000, pp};
      ST_P1, ST_P2: res = {8'h00, pp, 8'h00};
      ST_P3:        res = {pp, 16'h0000};
      default:      res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul8x8_core.sv
// Combinational unsigned 8x8 -> 16-bit exact multiplier shared by all
// partial-product steps of mul16_seq.
module mul8x8_core
  import mul_pkg::*;
(
  input  logic [HALF_W-1:0]   x,
  input  logic [HALF_W-1:0]   w,
  output logic [2*HALF_W-1:0] p
);

  // Operands are zero-extended so the product is formed at full 16-bit width.
  always_comb begin
    p = {8'h00, x} * {8'h00, w};
  end

endmodule

// File: rtl/mul16_seq.sv
// Sequential unsigned 16x16 -> 32 multiplier built from one 8x8 core over
// four cycles. Optional MAC mode is enabled by defining MUL16_SEQ_ACC_EN.
module mul16_seq
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
`ifdef MUL16_SEQ_ACC_EN
  input  logic              acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] y,
  output logic              busy
);

  state_e              state_r;
  state_e              state_s;
  logic [OP_W-1:0]     a_r;
  logic [OP_W-1:0]     b_r;
  logic [PROD_W-1:0]   acc_r;
  logic [PROD_W-1:0]   acc_start_s;
  logic [PROD_W-1:0]   y_r;
  logic                out_valid_r;
  logic                accept_s;
  logic                take_s;
  logic [HALF_W-1:0]   core_x_s;
  logic [HALF_W-1:0]   core_w_s;
  logic [2*HALF_W-1:0] core_p_s;

  assign accept_s  = in_valid && (state_r == ST_IDLE);
  assign take_s    = out_valid_r && out_ready && (state_r == ST_DONE);
  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign y         = y_r;

`ifdef MUL16_SEQ_ACC_EN
  // MAC mode seeds the accumulator with the previous product unless cleared.
  always_comb begin
    acc_start_s = 32'h0000_0000;
    if (acc_clr) begin
      acc_start_s = 32'h0000_0000;
    end else begin
      acc_start_s = y_r;
    end
  end
`else
  // Every operation starts from zero.
  always_comb begin
    acc_start_s = 32'h0000_0000;
  end
`endif

  // Operand muxes steering the captured halves into the shared core.
  always_comb begin
    core_x_s = a_r[HALF_W-1:0];
    core_w_s = b_r[HALF_W-1:0];
    case (state_r)
      ST_P0: begin
        core_x_s = a_r[HALF_W-1:0];
        core_w_s = b_r[HALF_W-1:0];
      end
      ST_P1: begin
        core_x_s = a_r[HALF_W-1:0];
        core_w_s = b_r[OP_W-1:HALF_W];
      end
      ST_P2: begin
        core_x_s = a_r[OP_W-1:HALF_W];
        core_w_s = b_r[HALF_W-1:0];
      end
      ST_P3: begin
        core_x_s = a_r[OP_W-1:HALF_W];
        core_w_s = b_r[OP_W-1:HALF_W];
      end
      default: begin
        core_x_s = a_r[HALF_W-1:0];
        core_w_s = b_r[HALF_W-1:0];
      end
    endcase
  end

  mul8x8_core u_core (
    .x (core_x_s),
    .w (core_w_s),
    .p (core_p_s)
  );

  // Next-state logic; DONE only releases once the registered result was offered.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_P0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_P0: state_s = ST_P1;
      ST_P1: state_s = ST_P2;
      ST_P2: state_s = ST_P3;
      ST_P3: state_s = ST_DONE;
      ST_DONE: begin
        if (take_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and partial-product accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 16'h0000;
      b_r   <= 16'h0000;
      acc_r <= 32'h0000_0000;
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      acc_r <= acc_start_s;
    end else if ((state_r == ST_P0) || (state_r == ST_P1) ||
                 (state_r == ST_P2) || (state_r == ST_P3)) begin
      acc_r <= acc_r + place_partial(core_p_s, state_r);
    end else begin
      acc_r <= acc_r;
    end
  end

  // Output register: loaded once per operation in DONE, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= 32'h0000_0000;
      out_valid_r <= 1'b0;
    end else if ((state_r == ST_DONE) && !out_valid_r) begin
      y_r         <= acc_r;
      out_valid_r <= 1'b1;
    end else if (take_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed and randomised self-checking bench for mul16_seq (MAC checks only
// when MUL16_SEQ_ACC_EN is defined).
module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int checks;
  int failures;

  mul16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MUL16_SEQ_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE, optionally churning inputs while busy,
  // then complete the output handshake. Returns result and latency in edges.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic clr,
                        input bit churn, output logic [31:0] yv, output int lat);
    @(negedge clk);
    a = av; b = bv; acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (churn) begin
        a = 16'($urandom); b = 16'($urandom); acc_clr = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    yv = y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] yv;
  logic [31:0] y_hold;
  logic [15:0] ra;
  logic [15:0] rb;
  int          lat;
  bit          seen_valid;
  bit          stable;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    acc_clr = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_y", y, 32'h0000_0000);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Abort during P2: accept, P0, P1 -> now in P2.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("abort_busy_p2", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; #2;
    check_eq("abort_y", y, 32'h0000_0000);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("abort_y_after", y, 32'h0000_0000);

    // Basic product and latency.
    run_op(16'h1234, 16'h5678, 1'b1, 1'b0, yv, lat);
    check_eq("basic_y", yv, 32'h0626_0060);
    check_eq("basic_latency", 32'(lat), 32'd5);
    check_eq("basic_idle_ready", {31'd0, in_ready}, 32'd1);
    check_eq("basic_idle_valid", {31'd0, out_valid}, 32'd0);
    check_eq("basic_y_held_idle", y, 32'h0626_0060);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, yv, lat);
    check_eq("max_y", yv, 32'hFFFE_0001);
    run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, yv, lat);
    check_eq("zero_y", yv, 32'h0000_0000);
    run_op(16'h0100, 16'h0001, 1'b1, 1'b1, yv, lat);
    check_eq("churn_y", yv, 32'h0000_0100);

    // Backpressure: hold out_ready low 10 cycles in DONE.
    @(negedge clk);
    a = 16'h0003; b = 16'h0005; acc_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
    y_hold = y;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (y !== y_hold || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("bp_stable", {31'd0, stable}, 32'd1);
    check_eq("bp_y", y, 32'h0000_000F);
    // Simultaneous new request and output take in DONE.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0007; b = 16'h0009;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_idle", {31'd0, busy}, 32'd0);
    check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_eq("overlap_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("overlap_accepted", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("overlap_y", y, 32'h0000_003F);
    check_eq("overlap_latency", 32'(lat), 32'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

`ifdef MUL16_SEQ_ACC_EN
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, yv, lat);
    check_eq("mac_op1", yv, 32'hFFFE_0001);
    run_op(16'h0002, 16'h0001, 1'b0, 1'b0, yv, lat);
    check_eq("mac_op2", yv, 32'hFFFE_0003);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, yv, lat);
    check_eq("mac_op3", yv, 32'h3FFE_0003);
`endif

    // Random back-to-back ops with input churn against a plain product.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 1'b1, 1'b1, yv, lat);
      check_eq("rand_y", yv, {16'h0000, ra} * {16'h0000, rb});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
